xosera_bus_host: RTL and testbench



---
 rtl/xosera_bus_host_if.sv | 31 +++
 rtl/xosera_bus_host.sv | 131 +++++++++++++
 tb/tb_xosera_bus_host.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xosera_bus_host_if.sv
// Request/response and Xosera byte-bus signals of xosera_bus_host, bundled for port connection.
// The slave modport is the host engine's view; master is the requester plus Xosera side.
interface xosera_bus_host_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_rd_nwr_i;
  logic [1:0]  req_mode_i;
  logic [3:0]  req_reg_num_i;
  logic [15:0] req_data_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        busy_o;
  logic        bus_cs_n_o;
  logic        bus_rd_nwr_o;
  logic        bus_bytesel_o;
  logic [3:0]  bus_reg_num_o;
  logic [7:0]  bus_data_o;
  logic [7:0]  bus_data_i;

  modport slave (
    input  req_valid_i, req_rd_nwr_i, req_mode_i, req_reg_num_i, req_data_i, bus_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, busy_o, bus_cs_n_o, bus_rd_nwr_o,
           bus_bytesel_o, bus_reg_num_o, bus_data_o
  );

  modport master (
    output req_valid_i, req_rd_nwr_i, req_mode_i, req_reg_num_i, req_data_i, bus_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, busy_o, bus_cs_n_o, bus_rd_nwr_o,
           bus_bytesel_o, bus_reg_num_o, bus_data_o
  );
endinterface

// File: rtl/xosera_bus_host.sv
// Xosera 8-bit register bus initiator: turns one 16-bit register request into
// high-then-low byte strobes with programmable setup, strobe and gap timing.
module xosera_bus_host #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned CS_CYCLES    = 4,
  parameter int unsigned SAMPLE_CYCLE = 2,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input logic              clk,
  input logic              reset_i,
  xosera_bus_host_if.slave host_if
);

  localparam logic [7:0] SetupLast = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] CsLast    = 8'(CS_CYCLES - 1);
  localparam logic [7:0] SampleIdx = 8'(SAMPLE_CYCLE);
  localparam logic [7:0] GapLast   = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StGap} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        word_q, word_d;
  logic        rd_q, rd_d;
  logic [3:0]  reg_q, reg_d;
  logic [15:0] data_q, data_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      phase_q     <= 1'b0;
      word_q      <= 1'b0;
      rd_q        <= 1'b1;
      reg_q       <= 4'd0;
      data_q      <= 16'd0;
      rsp_data_q  <= 16'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      word_q      <= word_d;
      rd_q        <= rd_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    word_d      = word_q;
    rd_d        = rd_q;
    reg_d       = reg_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (host_if.req_valid_i) begin
          rd_d       = host_if.req_rd_nwr_i;
          // Mode 11 behaves as a full word.
          word_d     = (host_if.req_mode_i == 2'b00) || (host_if.req_mode_i == 2'b11);
          phase_d    = (host_if.req_mode_i == 2'b01);
          reg_d      = host_if.req_reg_num_i;
          data_d     = host_if.req_data_i;
          rsp_data_d = 16'd0;
          cnt_d      = 8'd0;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = 8'd0;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StStrobe: begin
        if (rd_q && (cnt_q == SampleIdx)) begin
          if (phase_q) rsp_data_d[7:0]  = host_if.bus_data_i;
          else         rsp_data_d[15:8] = host_if.bus_data_i;
        end
        if (cnt_q == CsLast) begin
          cnt_d   = 8'd0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = 8'd0;
          if (word_q && !phase_q) begin
            phase_d = 1'b1;
            state_d = StSetup;
          end else begin
            rsp_valid_d = rd_q;
            state_d     = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only; nothing combinational from req_* or bus_data_i.
  always_comb begin
    host_if.req_ready_o   = (state_q == StIdle);
    host_if.busy_o        = (state_q != StIdle);
    host_if.rsp_valid_o   = rsp_valid_q;
    host_if.rsp_data_o    = rsp_data_q;
    host_if.bus_cs_n_o    = (state_q != StStrobe);
    host_if.bus_rd_nwr_o  = rd_q;
    host_if.bus_bytesel_o = phase_q;
    host_if.bus_reg_num_o = reg_q;
    host_if.bus_data_o    = 8'd0;
    if (!rd_q) host_if.bus_data_o = phase_q ? data_q[7:0] : data_q[15:8];
  end

endmodule

// File: tb/tb_xosera_bus_host.sv
// Scoreboard bench for xosera_bus_host: a register-file model answers bus strobes and a
// reference model predicts strobes, read data and handshake latency.
module tb_xosera_bus_host;
  localparam int unsigned S = 1, C = 4, SC = 2, G = 4;

  typedef struct packed {
    logic       rd;
    logic       bsel;
    logic [3:0] rn;
    logic [7:0] data;
  } stb_t;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  xosera_bus_host_if bus_if();

  xosera_bus_host #(
    .SETUP_CYCLES(S), .CS_CYCLES(C), .SAMPLE_CYCLE(SC), .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .host_if(bus_if.slave)
  );

  int tests = 0;
  int fails = 0;
  int ncyc  = 0;

  stb_t        stb_q[$];
  logic [15:0] rsp_q[$];
  int          falls[$];
  logic [15:0] ref_mem[16];
  logic [15:0] bus_mem[16];
  bit          discard = 0;
  int          acc_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stb_t cur_sig();
    return '{rd: bus_if.bus_rd_nwr_o, bsel: bus_if.bus_bytesel_o,
             rn: bus_if.bus_reg_num_o, data: bus_if.bus_data_o};
  endfunction

  always @(posedge clk) ncyc <= ncyc + 1;

  // Xosera stand-in: read byte is valid only on the intended sample cycle of the strobe.
  int stb_idx = 0;
  always @(negedge clk) begin
    if (!bus_if.bus_cs_n_o) begin
      if (stb_idx == SC)
        bus_if.bus_data_i = bus_if.bus_bytesel_o ? bus_mem[bus_if.bus_reg_num_o][7:0]
                                                 : bus_mem[bus_if.bus_reg_num_o][15:8];
      else
        bus_if.bus_data_i = 8'($urandom);
      if (!bus_if.bus_rd_nwr_o && stb_idx == 0) begin
        if (bus_if.bus_bytesel_o) bus_mem[bus_if.bus_reg_num_o][7:0]  = bus_if.bus_data_o;
        else                      bus_mem[bus_if.bus_reg_num_o][15:8] = bus_if.bus_data_o;
      end
      stb_idx++;
    end else begin
      stb_idx = 0;
      bus_if.bus_data_i = 8'($urandom);
    end
  end

  // Bus monitor: each cs-low pulse is compared against the next predicted strobe.
  logic prev_cs = 1'b1;
  stb_t prev_sig, cur;
  int   len;
  bit   held_ok;
  always @(negedge clk) begin
    if (!bus_if.bus_cs_n_o) begin
      if (prev_cs) begin
        cur     = cur_sig();
        len     = 1;
        held_ok = 1;
        falls.push_back(ncyc);
        check("setup_matches_strobe", 32'(prev_sig), 32'(cur));
      end else begin
        len++;
        if (cur_sig() != cur) held_ok = 0;
      end
    end else if (!prev_cs) begin
      if (discard) begin
        discard = 0;
      end else if (stb_q.size() == 0) begin
        check("unexpected_strobe", 32'(cur), 32'h0);
      end else begin
        check("strobe_fields", 32'(cur), 32'(stb_q.pop_front()));
        check("strobe_len", 32'(len), 32'(C));
        check("strobe_held", 32'(held_ok), 32'd1);
      end
    end
    prev_cs  = bus_if.bus_cs_n_o;
    prev_sig = cur_sig();
  end

  // Response monitor.
  always @(negedge clk) begin
    if (bus_if.rsp_valid_o) begin
      if (rsp_q.size() == 0) check("unexpected_rsp", 32'(bus_if.rsp_data_o), 32'h0);
      else                   check("rsp_data", 32'(bus_if.rsp_data_o), 32'(rsp_q.pop_front()));
    end
  end

  // Reference model: predicted strobes, read data and accept-to-ready latency.
  task automatic predict(input logic rd, input logic [1:0] mode, input logic [3:0] rn,
                         input logic [15:0] d, output int lat);
    bit hi = (mode != 2'b01);
    bit lo = (mode != 2'b10);
    logic [15:0] exp = 16'h0;
    if (hi) stb_q.push_back('{rd: rd, bsel: 1'b0, rn: rn, data: rd ? 8'h00 : d[15:8]});
    if (lo) stb_q.push_back('{rd: rd, bsel: 1'b1, rn: rn, data: rd ? 8'h00 : d[7:0]});
    if (rd) begin
      if (hi) exp[15:8] = ref_mem[rn][15:8];
      if (lo) exp[7:0]  = ref_mem[rn][7:0];
      rsp_q.push_back(exp);
    end else begin
      if (hi) ref_mem[rn][15:8] = d[15:8];
      if (lo) ref_mem[rn][7:0]  = d[7:0];
    end
    lat = (hi && lo) ? 2 * (S + C + G) + 1 : S + C + G + 1;
  endtask

  task automatic do_req(input logic rd, input logic [1:0] mode, input logic [3:0] rn,
                        input logic [15:0] d, input bit noise);
    int lat, n;
    predict(rd, mode, rn, d, lat);
    bus_if.req_valid_i   = 1'b1;
    bus_if.req_rd_nwr_i  = rd;
    bus_if.req_mode_i    = mode;
    bus_if.req_reg_num_i = rn;
    bus_if.req_data_i    = d;
    n = 0;
    while (!bus_if.req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = ncyc;
    @(posedge clk);
    #1 bus_if.req_valid_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus_if.req_valid_i = 1'b0;
      // Requests pulsed while busy must be ignored.
      if (noise && n + 3 <= lat && $urandom_range(0, 2) == 0) begin
        bus_if.req_valid_i   = 1'b1;
        bus_if.req_rd_nwr_i  = 1'($urandom);
        bus_if.req_mode_i    = 2'($urandom);
        bus_if.req_reg_num_i = 4'($urandom);
        bus_if.req_data_i    = 16'($urandom);
      end
    end while (!bus_if.req_ready_o && n < 200);
    check("accept_to_ready", 32'(n), 32'(lat));
    check("rsp_valid_at_ready", 32'(bus_if.rsp_valid_o), 32'(rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int exp_falls[4] = '{2, 11, 21, 30};
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'h1357 ^ (16'(i) * 16'h0F11);
      bus_mem[i] = 16'h1357 ^ (16'(i) * 16'h0F11);
    end
    ref_mem[10] = 16'hABCD;
    bus_mem[10] = 16'hABCD;
    reset_i              = 1'b1;
    bus_if.req_valid_i   = 1'b0;
    bus_if.req_rd_nwr_i  = 1'b0;
    bus_if.req_mode_i    = 2'b00;
    bus_if.req_reg_num_i = 4'd0;
    bus_if.req_data_i    = 16'd0;
    bus_if.bus_data_i    = 8'd0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    check("rst_ready", 32'(bus_if.req_ready_o), 32'd1);
    check("rst_busy", 32'(bus_if.busy_o), 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
    check("rst_rsp_data", 32'(bus_if.rsp_data_o), 32'd0);
    check("rst_cs_n", 32'(bus_if.bus_cs_n_o), 32'd1);
    check("rst_rd_nwr", 32'(bus_if.bus_rd_nwr_o), 32'd1);
    check("rst_bytesel", 32'(bus_if.bus_bytesel_o), 32'd0);
    check("rst_reg_num", 32'(bus_if.bus_reg_num_o), 32'd0);
    check("rst_bus_data", 32'(bus_if.bus_data_o), 32'd0);
    @(negedge clk);

    do_req(1'b0, 2'b00, 4'd6, 16'hD070, 1'b0);
    do_req(1'b1, 2'b00, 4'd10, 16'h0000, 1'b0);
    do_req(1'b0, 2'b01, 4'd5, 16'h1234, 1'b0);
    do_req(1'b1, 2'b10, 4'd5, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);

    // Back-to-back word writes: second accept must land exactly when ready returns.
    falls.delete();
    do_req(1'b0, 2'b00, 4'd3, 16'hBEEF, 1'b1);
    a0 = acc_cyc;
    do_req(1'b0, 2'b00, 4'd4, 16'hCAFE, 1'b1);
    check("b2b_second_accept", 32'(acc_cyc - a0), 32'd19);
    check("b2b_fall_count", 32'(falls.size()), 32'd4);
    for (int i = 0; i < 4 && i < falls.size(); i++)
      check("b2b_cs_fall_cycle", 32'(falls[i] - a0), 32'(exp_falls[i]));

    // Reset in the middle of a read strobe drops the transaction.
    bus_if.req_valid_i   = 1'b1;
    bus_if.req_rd_nwr_i  = 1'b1;
    bus_if.req_mode_i    = 2'b00;
    bus_if.req_reg_num_i = 4'd7;
    @(posedge clk);
    #1 bus_if.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_cs_low", 32'(bus_if.bus_cs_n_o), 32'd0);
    reset_i = 1'b1;
    discard = 1;
    @(negedge clk);
    reset_i = 1'b0;
    check("post_reset_cs_n", 32'(bus_if.bus_cs_n_o), 32'd1);
    check("post_reset_ready", 32'(bus_if.req_ready_o), 32'd1);
    check("post_reset_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
    check("post_reset_rsp_data", 32'(bus_if.rsp_data_o), 32'd0);
    repeat (25) @(negedge clk);
    do_req(1'b1, 2'b00, 4'd7, 16'h0000, 1'b0);

    for (int i = 0; i < 40; i++)
      do_req(1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom), 1'b1);

    repeat (3) @(negedge clk);
    check("strobe_queue_drained", 32'(stb_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
